regbank_wr_arbiter: RTL and testbench

- Round-robin arbiter that shares the single write port of the flip-flop register bank among NUM_REQ requesters.
- Grants one requester at a time using a req/gnt handshake and registers the winner's address and data.
- Drives the bank's write-enable, address and data lines.
- A requester may lock the port for a bounded burst of back-to-back writes.

---
 rtl/regbank_wr_arbiter.sv | 150 +++++++++++++++
 tb/tb_regbank_wr_arbiter.sv | 135 +++++++++++++
 2 files changed

// File: rtl/regbank_wr_arbiter.sv
// regbank_wr_arbiter: round-robin arbiter sharing one register-bank write port among NUM_REQ requesters.
//   clk_in/reset_in         : clock, synchronous active-high reset
//   req_in/lock_in          : per-requester write request and burst lock
//   addr_in/data_in         : packed per-requester address/data slices
//   gnt_out/grant_id_out    : registered one-hot grant and granted index
//   busy_out                : arbiter is not idle
//   bank_we_out/addr/data   : registered write strobe, address and data to the bank
//   starve_out              : per-requester starvation flag (only with REGBANK_ARB_STARVE_EN)
module regbank_wr_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int ADDR_W   = 3,
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic                          clk_in,
  input  logic                          reset_in,
  input  logic [NUM_REQ-1:0]            req_in,
  input  logic [NUM_REQ-1:0]            lock_in,
  input  logic [NUM_REQ*ADDR_W-1:0]     addr_in,
  input  logic [NUM_REQ*DATA_W-1:0]     data_in,
  output logic [NUM_REQ-1:0]            gnt_out,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id_out,
  output logic                          busy_out,
  output logic                          bank_we_out,
  output logic [ADDR_W-1:0]             bank_addr_out,
`ifdef REGBANK_ARB_STARVE_EN
  output logic [DATA_W-1:0]             bank_data_out,
  output logic [NUM_REQ-1:0]            starve_out
`else
  output logic [DATA_W-1:0]             bank_data_out
`endif
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam int HW  = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  typedef enum logic [1:0] {IDLE, GRANT, HOLD} state_t;
  state_t              state_q, state_d;
  logic [IDW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [HW-1:0]       hold_q, hold_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [IDW-1:0]      gid_q, gid_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [IDW-1:0]      rr_pick, win, next_ptr;
  logic                found, stop_burst;
  always_comb begin
    rr_pick = '0;
    found   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req_in[IDW'((int'(rr_ptr_q) + k) % NUM_REQ)]) begin
        found   = 1'b1;
        rr_pick = IDW'((int'(rr_ptr_q) + k) % NUM_REQ);
      end
    end
  end
`ifdef REGBANK_ARB_STARVE_EN
  logic [4:0]         wait_q [NUM_REQ];
  logic [4:0]         wait_d [NUM_REQ];
  logic [NUM_REQ-1:0] starve_q, starve_d;
  logic [IDW-1:0]     st_pick;
  always_comb begin
    st_pick = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (starve_q[IDW'(k)]) st_pick = IDW'(k);
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      wait_d[k]   = (!req_in[IDW'(k)] || gnt_q[IDW'(k)]) ? 5'd0 :
                    (&wait_q[k]) ? wait_q[k] : wait_q[k] + 5'd1;
      starve_d[k] = wait_d[k][4];
    end
  end
  // a starving requester overrides the rotation and cuts short anyone else's burst
  assign win        = (|starve_q) ? st_pick : rr_pick;
  assign stop_burst = |(starve_q & ~gnt_q);
  assign starve_out = starve_q;
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      starve_q <= '0;
      for (int k = 0; k < NUM_REQ; k++) wait_q[k] <= '0;
    end else begin
      starve_q <= starve_d;
      for (int k = 0; k < NUM_REQ; k++) wait_q[k] <= wait_d[k];
    end
  end
`else
  assign win        = rr_pick;
  assign stop_burst = 1'b0;
`endif
  assign next_ptr = (gid_q == IDW'(NUM_REQ - 1)) ? '0 : gid_q + 1'b1;
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    hold_d   = hold_q;
    gnt_d    = gnt_q;
    gid_d    = gid_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    data_d   = data_q;
    if (state_q == IDLE) begin
      if (|req_in) begin
        gnt_d   = NUM_REQ'(1) << win;
        gid_d   = win;
        hold_d  = '0;
        state_d = GRANT;
      end
    end else begin
      // acceptance or withdrawal both release the grant unless a lock extends it
      rr_ptr_d = next_ptr;
      gnt_d    = '0;
      state_d  = IDLE;
      if (req_in[gid_q]) begin
        we_d   = 1'b1;
        addr_d = addr_in[gid_q*ADDR_W +: ADDR_W];
        data_d = data_in[gid_q*DATA_W +: DATA_W];
        if (lock_in[gid_q] && hold_q < HW'(MAX_HOLD - 1) && !stop_burst) begin
          hold_d  = hold_q + 1'b1;
          gnt_d   = gnt_q;
          state_d = HOLD;
        end
      end
    end
  end
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      hold_q   <= '0;
      gnt_q    <= '0;
      gid_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      hold_q   <= hold_d;
      gnt_q    <= gnt_d;
      gid_q    <= gid_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
    end
  end
  assign gnt_out       = gnt_q;
  assign grant_id_out  = gid_q;
  assign busy_out      = state_q != IDLE;
  assign bank_we_out   = we_q;
  assign bank_addr_out = addr_q;
  assign bank_data_out = data_q;
endmodule

// File: tb/tb_regbank_wr_arbiter.sv
// tb_regbank_wr_arbiter: directed table, burst sequence and randomized model check of regbank_wr_arbiter.
module tb_regbank_wr_arbiter;
  localparam int N = 4, AW = 3, DW = 8, MH = 4;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic              rst;
  logic [N-1:0]      req, lock;
  logic [N*AW-1:0]   addr;
  logic [N*DW-1:0]   data;
  logic [N-1:0]      gnt;
  logic [1:0]        gid;
  logic              busy, we;
  logic [AW-1:0]     baddr;
  logic [DW-1:0]     bdata;
`ifdef REGBANK_ARB_STARVE_EN
  logic [N-1:0]      starve;
`endif
  regbank_wr_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(MH)) dut (
    .clk_in(clk), .reset_in(rst), .req_in(req), .lock_in(lock),
    .addr_in(addr), .data_in(data), .gnt_out(gnt), .grant_id_out(gid),
    .busy_out(busy), .bank_we_out(we), .bank_addr_out(baddr),
`ifdef REGBANK_ARB_STARVE_EN
    .bank_data_out(bdata), .starve_out(starve)
`else
    .bank_data_out(bdata)
`endif
  );
  int checks = 0, fails = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  // reference model: owner is the granted requester or -1 when idle
  int owner = -1, ptr = 0, burst = 0, m_gid = 0, m_we = 0, m_addr = 0, m_data = 0;
  task automatic step();
    @(posedge clk);
    if (rst) begin
      owner = -1; ptr = 0; burst = 0; m_gid = 0; m_we = 0; m_addr = 0; m_data = 0;
    end else begin
      m_we = 0;
      if (owner < 0) begin
        for (int k = 0; k < N; k++)
          if (owner < 0 && req[(ptr + k) % N]) owner = (ptr + k) % N;
        if (owner >= 0) begin m_gid = owner; burst = 1; end
      end else begin
        ptr = (owner + 1) % N;
        if (req[owner]) begin
          m_we = 1;
          m_addr = int'((addr >> (owner * AW)) & ((1 << AW) - 1));
          m_data = int'((data >> (owner * DW)) & ((1 << DW) - 1));
          if (lock[owner] && burst < MH) burst++;
          else owner = -1;
        end else owner = -1;
      end
    end
    #1;
  endtask
  typedef struct {
    logic rst; logic [N-1:0] req;
    logic [N-1:0] gnt; logic busy; logic we; logic [AW-1:0] a; logic [DW-1:0] d;
  } vec_t;
  vec_t tbl [23];
  initial begin
    tbl[0]  = '{1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 3'd0, 8'h00};
    tbl[1]  = '{1'b0, 4'b0001, 4'b0001, 1'b1, 1'b0, 3'd0, 8'h00};
    tbl[2]  = '{1'b0, 4'b0001, 4'b0000, 1'b0, 1'b1, 3'd5, 8'hA5};
    tbl[3]  = '{1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 3'd5, 8'hA5};
    tbl[4]  = '{1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 3'd0, 8'h00};
    tbl[5]  = '{1'b0, 4'b1111, 4'b0001, 1'b1, 1'b0, 3'd0, 8'h00};
    tbl[6]  = '{1'b0, 4'b1111, 4'b0000, 1'b0, 1'b1, 3'd5, 8'hA5};
    tbl[7]  = '{1'b0, 4'b1111, 4'b0010, 1'b1, 1'b0, 3'd5, 8'hA5};
    tbl[8]  = '{1'b0, 4'b1111, 4'b0000, 1'b0, 1'b1, 3'd6, 8'hB6};
    tbl[9]  = '{1'b0, 4'b1111, 4'b0100, 1'b1, 1'b0, 3'd6, 8'hB6};
    tbl[10] = '{1'b0, 4'b1111, 4'b0000, 1'b0, 1'b1, 3'd7, 8'hC7};
    tbl[11] = '{1'b0, 4'b1111, 4'b1000, 1'b1, 1'b0, 3'd7, 8'hC7};
    tbl[12] = '{1'b0, 4'b1111, 4'b0000, 1'b0, 1'b1, 3'd0, 8'hD8};
    tbl[13] = '{1'b0, 4'b1111, 4'b0001, 1'b1, 1'b0, 3'd0, 8'hD8};
    tbl[14] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 3'd0, 8'hD8};
    tbl[15] = '{1'b0, 4'b0010, 4'b0010, 1'b1, 1'b0, 3'd0, 8'hD8};
    tbl[16] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 3'd0, 8'hD8};
    tbl[17] = '{1'b0, 4'b0110, 4'b0100, 1'b1, 1'b0, 3'd0, 8'hD8};
    tbl[18] = '{1'b0, 4'b0110, 4'b0000, 1'b0, 1'b1, 3'd7, 8'hC7};
    tbl[19] = '{1'b0, 4'b0001, 4'b0001, 1'b1, 1'b0, 3'd7, 8'hC7};
    tbl[20] = '{1'b1, 4'b0001, 4'b0000, 1'b0, 1'b0, 3'd0, 8'h00};
    tbl[21] = '{1'b0, 4'b0011, 4'b0001, 1'b1, 1'b0, 3'd0, 8'h00};
    tbl[22] = '{1'b0, 4'b0011, 4'b0000, 1'b0, 1'b1, 3'd5, 8'hA5};
    lock = '0;
    addr = {3'd0, 3'd7, 3'd6, 3'd5};
    data = {8'hD8, 8'hC7, 8'hB6, 8'hA5};
    for (int i = 0; i < 23; i++) begin
      rst = tbl[i].rst;
      req = tbl[i].req;
      step();
      chk($sformatf("row%0d_gnt", i), 32'(gnt), 32'(tbl[i].gnt));
      chk($sformatf("row%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
      chk($sformatf("row%0d_we", i), 32'(we), 32'(tbl[i].we));
      chk($sformatf("row%0d_addr", i), 32'(baddr), 32'(tbl[i].a));
      chk($sformatf("row%0d_data", i), 32'(bdata), 32'(tbl[i].d));
    end
    // locked burst by requester 2 with requester 3 waiting
    rst = 1'b0; req = 4'b1100; lock = 4'b0100;
    step();
    chk("burst_grant", 32'(gnt), 32'h4);
    chk("burst_grant_we", 32'(we), 32'h0);
    for (int i = 0; i < MH; i++) begin
      step();
      chk($sformatf("burst%0d_we", i), 32'(we), 32'h1);
      chk($sformatf("burst%0d_data", i), 32'(bdata), 32'hC7);
      chk($sformatf("burst%0d_gnt", i), 32'(gnt), (i < MH - 1) ? 32'h4 : 32'h0);
    end
    step();
    chk("after_burst_gnt", 32'(gnt), 32'h8);
    chk("after_burst_we", 32'(we), 32'h0);
    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rst  = ($urandom_range(0, 59) == 0);
      req  = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
      lock = N'($urandom);
      addr = (N*AW)'($urandom);
      data = (N*DW)'({$urandom, $urandom});
      step();
      chk("rnd_gnt", 32'(gnt), owner < 0 ? 32'h0 : 32'(1 << owner));
      chk("rnd_busy", 32'(busy), 32'(owner >= 0));
      chk("rnd_we", 32'(we), 32'(m_we));
      chk("rnd_addr", 32'(baddr), 32'(m_addr));
      chk("rnd_data", 32'(bdata), 32'(m_data));
      if (owner >= 0) chk("rnd_gid", 32'(gid), 32'(m_gid));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
